// File: rtl/cdc_sync_filter_if.sv
// Bundles the per-channel level inputs, control and filtered outputs of
// cdc_sync_filter. The bench drives through master, the synchronizer uses slave.
interface cdc_sync_filter_if #(
    parameter int pWIDTH = 8
);
    logic [pWIDTH-1:0] data_in;
    logic              filter_en;
    logic [pWIDTH-1:0] clear_events;
    logic [pWIDTH-1:0] data_out;
    logic [pWIDTH-1:0] data_out_r;
    logic [pWIDTH-1:0] rise;
    logic [pWIDTH-1:0] fall;
    logic [pWIDTH-1:0] event_rise;
    logic [pWIDTH-1:0] event_fall;

    modport master (
        output data_in, filter_en, clear_events,
        input  data_out, data_out_r, rise, fall, event_rise, event_fall
    );

    modport slave (
        input  data_in, filter_en, clear_events,
        output data_out, data_out_r, rise, fall, event_rise, event_fall
    );
endinterface

// File: rtl/cdc_sync_filter.sv
// Multi-channel level synchronizer with optional per-channel glitch filter,
// one-cycle edge pulses and firmware-clearable sticky event flags.
module cdc_sync_filter #(
    parameter int pWIDTH         = 8,
    parameter int pPIPE_DEPTH    = 2,
    parameter int pFILTER_CYCLES = 4
) (
    input logic               clk,
    input logic               reset,
    cdc_sync_filter_if.slave  bus
);
    localparam int CW = $clog2(pFILTER_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(pFILTER_CYCLES - 1);

    (* ASYNC_REG = "TRUE" *) logic [pWIDTH-1:0] pipe [pPIPE_DEPTH];

    logic [pWIDTH-1:0] s;
    logic [CW-1:0]     cnt     [pWIDTH];
    logic [CW-1:0]     cnt_nxt [pWIDTH];
    logic [pWIDTH-1:0] upd;
    logic [pWIDTH-1:0] dout_q;
    logic [pWIDTH-1:0] dout_r_q;
    logic [pWIDTH-1:0] rise_q;
    logic [pWIDTH-1:0] fall_q;
    logic [pWIDTH-1:0] ev_rise_q;
    logic [pWIDTH-1:0] ev_fall_q;

    assign s = pipe[pPIPE_DEPTH-1];

    // Synchronizer chain: shift the raw inputs one stage per clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the pipe is a small register array, not RAM, so clearing
            // every stage on reset is cheap and keeps the first outputs defined.
            for (int k = 0; k < pPIPE_DEPTH; k++) begin
                pipe[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let every stage sample its
            // neighbour's old value, which is what makes this a shift chain.
            pipe[0] <= bus.data_in;
            for (int k = 1; k < pPIPE_DEPTH; k++) begin
                pipe[k] <= pipe[k-1];
            end
        end
    end

    // Filter decision: which channels accept s this edge, and their next count.
    always_comb begin
        for (int i = 0; i < pWIDTH; i++) begin
            // NOTE: defaults first so every path assigns both outputs and
            // no latch is inferred.
            upd[i]     = 1'b0;
            cnt_nxt[i] = '0;
            if (!bus.filter_en) begin
                upd[i] = (s[i] != dout_q[i]);
            end else if (s[i] != dout_q[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    upd[i] = 1'b1;
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    // Per-channel stability counters.
    always_ff @(posedge clk) begin
        for (int i = 0; i < pWIDTH; i++) begin
            if (reset) begin
                cnt[i] <= '0;
            end else begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    // Output value, delayed copy, edge pulses and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q    <= '0;
            dout_r_q  <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            ev_rise_q <= '0;
            ev_fall_q <= '0;
        end else begin
            dout_q    <= dout_q ^ upd;
            dout_r_q  <= dout_q;
            rise_q    <= upd & s;
            fall_q    <= upd & ~s;
            // A new event in the same cycle as a clear keeps the flag set.
            ev_rise_q <= (upd & s)  | (ev_rise_q & ~bus.clear_events);
            ev_fall_q <= (upd & ~s) | (ev_fall_q & ~bus.clear_events);
        end
    end

    assign bus.data_out   = dout_q;
    assign bus.data_out_r = dout_r_q;
    assign bus.rise       = rise_q;
    assign bus.fall       = fall_q;
    assign bus.event_rise = ev_rise_q;
    assign bus.event_fall = ev_fall_q;

endmodule
